// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-to-bridge request arbiter.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Index width for n channels, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational winner picker: first requesting index at or after a start
// point, wrapping around. Fixed priority is the same search started at zero.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic          rrMode_i,
    output logic          valid_o,
    output logic [IW-1:0] winner_o
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int base;
        int idx;
        logic [N-1:0] shifted;
        base     = rrMode_i ? int'(start_i) : 0;
        idx      = 0;
        shifted  = '0;
        valid_o  = |req_i;
        winner_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            shifted = req_i >> idx;
            if (shifted[0]) begin
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel arbiter in front of the single AXI bridge port: registers the
// winning request, holds it until the bridge completes, and flags stuck cycles.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 1,
    parameter int TIMEOUT  = 1024,
    localparam int GW      = idxWidth(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_access,
    input  logic [N_CH-1:0]          req_write,
    input  logic [2*N_CH-1:0]        req_size,
    input  logic [4*N_CH-1:0]        req_sel,
    input  logic [ADDR_W*N_CH-1:0]   req_addr,
    input  logic [DATA_W*N_CH-1:0]   req_wdata,
    output logic [N_CH-1:0]          req_ready,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     mem_access,
    output logic                     mem_write,
    output logic [1:0]               mem_size,
    output logic [3:0]               mem_sel,
    output logic [ADDR_W-1:0]        mem_a,
    output logic [DATA_W-1:0]        mem_st_data,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_ready,
    output logic [GW-1:0]            grant_id,
    output logic                     timeout_err
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] LAST_CH = GW'(N_CH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] ARM_AT  = CW'(TIMEOUT - 2);

    arb_state_e          state_q, state_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rrPtr_q, rrPtr_d;
    logic [CW-1:0]       wdogCnt_q, wdogCnt_d;
    logic                timeoutErr_q, timeoutErr_d;

    logic                pickValid;
    logic [GW-1:0]       pickIdx;
    logic [1:0]          sizeArr  [N_CH];
    logic [3:0]          selArr   [N_CH];
    logic [ADDR_W-1:0]   addrArr  [N_CH];
    logic [DATA_W-1:0]   wdataArr [N_CH];

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            sizeArr[c]  = req_size[2*c +: 2];
            selArr[c]   = req_sel[4*c +: 4];
            addrArr[c]  = req_addr[ADDR_W*c +: ADDR_W];
            wdataArr[c] = req_wdata[DATA_W*c +: DATA_W];
        end
    end

    rr_pick #(
        .N  (N_CH),
        .IW (GW)
    ) u_pick (
        .req_i    (req_access),
        .start_i  (rrPtr_q),
        .rrMode_i (ARB_MODE == ARB_RR),
        .valid_o  (pickValid),
        .winner_o (pickIdx)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant_d      = grant_q;
        rrPtr_d      = rrPtr_q;
        wdogCnt_d    = wdogCnt_q;
        timeoutErr_d = timeoutErr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pickValid) begin
                    state_d   = ARB_BUSY;
                    grant_d   = pickIdx;
                    write_d   = req_write[pickIdx];
                    size_d    = sizeArr[pickIdx];
                    sel_d     = selArr[pickIdx];
                    addr_d    = addrArr[pickIdx];
                    wdata_d   = wdataArr[pickIdx];
                    wdogCnt_d = '0;
                end
            end
            ARB_BUSY: begin
                if (wdogCnt_q != CNT_MAX) begin
                    wdogCnt_d = wdogCnt_q + 1'b1;
                end
                // The flag is registered, so arm it one edge early; it then
                // reads high from the TIMEOUT-th BUSY cycle onward.
                if (!mem_ready && wdogCnt_q >= ARM_AT) begin
                    timeoutErr_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = ARB_IDLE;
                    if (ARB_MODE == ARB_RR) begin
                        rrPtr_d = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            write_q      <= 1'b0;
            size_q       <= '0;
            sel_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            grant_q      <= '0;
            rrPtr_q      <= '0;
            wdogCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            grant_q      <= grant_d;
            rrPtr_q      <= rrPtr_d;
            wdogCnt_q    <= wdogCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Completion is steered straight from the bridge so there is no added latency.
    always_comb begin
        req_ready = '0;
        if (state_q == ARB_BUSY && mem_ready) begin
            req_ready = N_CH'(1) << grant_q;
        end
    end

    assign req_rdata   = mem_data;
    assign mem_access  = (state_q == ARB_BUSY);
    assign mem_write   = write_q;
    assign mem_size    = size_q;
    assign mem_sel     = sel_q;
    assign mem_a       = addr_q;
    assign mem_st_data = wdata_q;
    assign grant_id    = grant_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one
// stimulus stream; expected completions are queued and checked on req_ready.
module tb_mem_req_arbiter;

    localparam int N_CH = 3;
    localparam int TMO  = 8;

    typedef struct {
        int          ch;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_access;
    logic [2:0]  req_write;
    logic [5:0]  req_size;
    logic [11:0] req_sel;
    logic [95:0] req_addr;
    logic [95:0] req_wdata;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic [2:0]  ready  [2];
    logic [31:0] rdata  [2];
    logic [1:0]  access;
    logic [1:0]  memWrite;
    logic [1:0]  memSize [2];
    logic [3:0]  memSel  [2];
    logic [31:0] memA    [2];
    logic [31:0] stData  [2];
    logic [1:0]  grant   [2];
    logic [1:0]  tmo;

    logic [2:0]  accTab;
    logic        wrTab   [3];
    logic [1:0]  szTab   [3];
    logic [3:0]  selTab  [3];
    logic [31:0] addrTab [3];
    logic [31:0] wdTab   [3];

    exp_t qRr[$];
    exp_t qFx[$];
    int   nTests = 0;
    int   nFail  = 0;
    logic wdogExp = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        req_access = accTab;
        for (int c = 0; c < N_CH; c++) begin
            req_write[c]           = wrTab[c];
            req_size[2*c +: 2]     = szTab[c];
            req_sel[4*c +: 4]      = selTab[c];
            req_addr[32*c +: 32]   = addrTab[c];
            req_wdata[32*c +: 32]  = wdTab[c];
        end
    end

    mem_req_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(TMO)) dutRr (
        .clk(clk), .rst(rst),
        .req_access(req_access), .req_write(req_write), .req_size(req_size),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ready[0]), .req_rdata(rdata[0]),
        .mem_access(access[0]), .mem_write(memWrite[0]), .mem_size(memSize[0]),
        .mem_sel(memSel[0]), .mem_a(memA[0]), .mem_st_data(stData[0]),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .grant_id(grant[0]), .timeout_err(tmo[0])
    );

    mem_req_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(TMO)) dutFx (
        .clk(clk), .rst(rst),
        .req_access(req_access), .req_write(req_write), .req_size(req_size),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(ready[1]), .req_rdata(rdata[1]),
        .mem_access(access[1]), .mem_write(memWrite[1]), .mem_size(memSize[1]),
        .mem_sel(memSel[1]), .mem_a(memA[1]), .mem_st_data(stData[1]),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .grant_id(grant[1]), .timeout_err(tmo[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadTables();
        wrTab[0] = 1'b0; szTab[0] = 2'b10; selTab[0] = 4'hF; addrTab[0] = 32'h0000_1000; wdTab[0] = 32'hA0A0_0000;
        wrTab[1] = 1'b0; szTab[1] = 2'b10; selTab[1] = 4'hF; addrTab[1] = 32'h1FC0_0100; wdTab[1] = 32'hB1B1_1111;
        wrTab[2] = 1'b1; szTab[2] = 2'b01; selTab[2] = 4'h3; addrTab[2] = 32'h0000_2000; wdTab[2] = 32'h1234_5678;
    endtask

    // One transaction: expect chRr/chFx granted, hold mem_* for nBusy cycles,
    // return rdata on the last BUSY cycle.
    task automatic applyStimulus(input int chRr, input int chFx, input int nBusy,
                                 input logic [31:0] rd, input bit scramble);
        int          ch [2];
        logic [31:0] sAddr [2];
        logic [31:0] sWd [2];
        logic [3:0]  sSel [2];
        logic [1:0]  sSz [2];
        logic        sWr [2];
        int          waitCyc;
        exp_t        e;
        ch[0] = chRr;
        ch[1] = chFx;
        for (int d = 0; d < 2; d++) begin
            sAddr[d] = addrTab[ch[d]];
            sWd[d]   = wdTab[ch[d]];
            sSel[d]  = selTab[ch[d]];
            sSz[d]   = szTab[ch[d]];
            sWr[d]   = wrTab[ch[d]];
        end
        e.rdata = rd;
        e.ch = chRr; qRr.push_back(e);
        e.ch = chFx; qFx.push_back(e);
        tick();
        checkOutput("access_latency", access, 2'b11);
        waitCyc = 0;
        while (access != 2'b11 && waitCyc < 20) begin
            tick();
            waitCyc++;
        end
        if (access != 2'b11) begin
            checkOutput("access_wait_expired", access, 2'b11);
            qRr.delete();
            qFx.delete();
            return;
        end
        for (int b = 1; b <= nBusy; b++) begin
            if (b >= TMO) wdogExp = 1'b1;
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("grant_id%0d", d), grant[d], ch[d]);
                checkOutput($sformatf("hold_addr%0d", d), memA[d], sAddr[d]);
                checkOutput($sformatf("hold_stdata%0d", d), stData[d], sWd[d]);
                checkOutput($sformatf("hold_sel%0d", d), memSel[d], sSel[d]);
                checkOutput($sformatf("hold_size%0d", d), memSize[d], sSz[d]);
                checkOutput($sformatf("hold_write%0d", d), memWrite[d], sWr[d]);
                checkOutput($sformatf("timeout_err%0d", d), tmo[d], wdogExp);
            end
            if (scramble && b == 1) begin
                for (int c = 0; c < N_CH; c++) begin
                    wrTab[c] = 1'b0; szTab[c] = 2'b00; selTab[c] = 4'h0;
                    addrTab[c] = 32'h0; wdTab[c] = 32'h0;
                end
            end
            if (b == nBusy) begin
                mem_ready = 1'b1;
                mem_data  = rd;
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_data  = 32'h0;
    endtask

    // Monitor: every req_ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin : scoreboardMonitor
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (ready[d] != 3'b000) begin
                have = (d == 0) ? (qRr.size() != 0) : (qFx.size() != 0);
                if (!have) begin
                    checkOutput($sformatf("spurious_ready%0d", d), ready[d], 0);
                end else begin
                    if (d == 0) e = qRr.pop_front();
                    else        e = qFx.pop_front();
                    checkOutput($sformatf("ready_onehot%0d", d), ready[d], 64'd1 << e.ch);
                    checkOutput($sformatf("rdata%0d", d), rdata[d], e.rdata);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        accTab = 3'b000;
        mem_ready = 1'b0;
        mem_data = 32'h0;
        loadTables();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst_mem_a%0d", d), memA[d], 0);
            checkOutput($sformatf("rst_stdata%0d", d), stData[d], 0);
            checkOutput($sformatf("rst_sel%0d", d), memSel[d], 0);
            checkOutput($sformatf("rst_size%0d", d), memSize[d], 0);
            checkOutput($sformatf("rst_grant%0d", d), grant[d], 0);
            checkOutput($sformatf("rst_ready%0d", d), ready[d], 0);
        end
        checkOutput("rst_access", access, 0);
        checkOutput("rst_write", memWrite, 0);
        checkOutput("rst_timeout", tmo, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single read on ch1");
        accTab = 3'b010;
        applyStimulus(1, 1, 3, 32'hDEAD_BEEF, 1'b0);
        accTab = 3'b000;
        tick();

        $display("[TB] store latch on ch2");
        accTab = 3'b100;
        applyStimulus(2, 2, 3, 32'h0000_0000, 1'b1);
        accTab = 3'b000;
        loadTables();
        tick();

        $display("[TB] three-way contention");
        accTab = 3'b111;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i % 3, 0, 1, 32'h100 + i, 1'b0);
        end
        accTab = 3'b000;
        tick();

        $display("[TB] ch0 and ch2 contention");
        accTab = 3'b101;
        applyStimulus(0, 0, 1, 32'h200, 1'b0);
        applyStimulus(2, 0, 1, 32'h201, 1'b0);
        applyStimulus(0, 0, 1, 32'h202, 1'b0);
        accTab = 3'b100;
        applyStimulus(2, 2, 1, 32'h203, 1'b0);
        accTab = 3'b000;
        tick();

        $display("[TB] mem_ready while idle");
        mem_ready = 1'b1;
        mem_data = 32'hFFFF_0000;
        #1;
        checkOutput("idle_ready0", ready[0], 0);
        checkOutput("idle_ready1", ready[1], 0);
        tick();
        mem_ready = 1'b0;
        mem_data = 32'h0;
        checkOutput("idle_access", access, 0);

        $display("[TB] reset during BUSY");
        accTab = 3'b001;
        applyStimulus(0, 0, 1, 32'h300, 1'b0);
        accTab = 3'b000;
        tick();
        accTab = 3'b010;
        tick();
        checkOutput("pre_rst_access", access, 2'b11);
        rst = 1'b1;
        mem_ready = 1'b1;
        mem_data = 32'hBAD0_BAD0;
        #1;
        checkOutput("midrst_access", access, 0);
        checkOutput("midrst_ready0", ready[0], 0);
        checkOutput("midrst_ready1", ready[1], 0);
        checkOutput("midrst_grant0", grant[0], 0);
        tick();
        accTab = 3'b111;
        rst = 1'b0;
        mem_ready = 1'b0;
        mem_data = 32'h0;
        wdogExp = 1'b0;
        applyStimulus(0, 0, 1, 32'h301, 1'b0);
        accTab = 3'b000;
        tick();

        $display("[TB] watchdog");
        accTab = 3'b001;
        applyStimulus(0, 0, 10, 32'h0BAD_F00D, 1'b0);
        accTab = 3'b000;
        tick();
        checkOutput("tmo_sticky_idle", tmo, 2'b11);
        accTab = 3'b010;
        applyStimulus(1, 1, 1, 32'h400, 1'b0);
        accTab = 3'b000;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("tmo_cleared_by_rst", tmo, 0);
        checkOutput("final_rst_access", access, 0);
        tick();
        rst = 1'b0;
        wdogExp = 1'b0;
        tick();

        checkOutput("queue_rr_drained", qRr.size(), 0);
        checkOutput("queue_fx_drained", qFx.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
